// File: rtl/axi_tx.sv
// AXI-Stream transmit end of the dataplane: buffers each incoming frame in a
// word FIFO and releases only committed frames, so dropped frames never reach TX.
module axi_tx #(
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 32
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              data_valid_in,
  input  logic [DATA_WIDTH-1:0]             tdata_in,
  input  logic [$clog2(DATA_WIDTH/8)-1:0]   idx_in,
  input  logic                              last_flag_in,
  input  logic                              drop_in,
  output logic                              in_ready,
  output logic                              tvalid,
  output logic [DATA_WIDTH-1:0]             tdata,
  output logic [DATA_WIDTH/8-1:0]           tkeep,
  output logic                              tlast,
  input  logic                              tready,
  output logic [31:0]                       tx_frame_cnt,
  output logic [31:0]                       drop_frame_cnt
);

  localparam int KEEP_W = DATA_WIDTH / 8;
  localparam int IDX_W  = $clog2(KEEP_W);
  localparam int AW     = $clog2(DEPTH);
  localparam int PW     = AW + 1;

  typedef enum logic {
    ACCEPT,
    DISCARD
  } wr_state_e;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic                  last;
    logic [KEEP_W-1:0]     keep;
  } entry_t;

  wr_state_e     state, state_nxt;
  logic [PW-1:0] wr_spec, wr_spec_nxt;
  logic [PW-1:0] wr_commit, wr_commit_nxt;
  logic [PW-1:0] rd;
  logic          full;
  logic          mem_we;
  logic          drop_inc;
  logic          avail;
  logic          load;
  logic [KEEP_W-1:0] last_keep;
  entry_t        wr_entry;
  entry_t        rd_entry;
  entry_t        mem [DEPTH];

  // Occupancy deliberately uses the registered rd: a pop this cycle frees no space.
  assign full     = (wr_spec - rd) == PW'(DEPTH);
  assign in_ready = !full;

  always_comb begin
    last_keep = '0;
    for (int i = 0; i < KEEP_W; i++) begin
      last_keep[i] = (IDX_W'(i) <= idx_in);
    end
  end

  assign wr_entry.data = tdata_in;
  assign wr_entry.last = last_flag_in;
  assign wr_entry.keep = last_flag_in ? last_keep : '1;

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt     = state;
    wr_spec_nxt   = wr_spec;
    wr_commit_nxt = wr_commit;
    mem_we        = 1'b0;
    drop_inc      = 1'b0;
    unique case (state)
      ACCEPT: begin
        if (data_valid_in) begin
          if (!full) begin
            if (!last_flag_in) begin
              mem_we      = 1'b1;
              wr_spec_nxt = wr_spec + PW'(1);
            end else if (!drop_in) begin
              mem_we        = 1'b1;
              wr_spec_nxt   = wr_spec + PW'(1);
              wr_commit_nxt = wr_spec + PW'(1);
            end else begin
              wr_spec_nxt = wr_commit;
              drop_inc    = 1'b1;
            end
          end else begin
            // Overflow: rewind to the last commit so no partial frame survives.
            wr_spec_nxt = wr_commit;
            if (last_flag_in) drop_inc  = 1'b1;
            else              state_nxt = DISCARD;
          end
        end
      end
      DISCARD: begin
        if (data_valid_in && last_flag_in) begin
          drop_inc  = 1'b1;
          state_nxt = ACCEPT;
        end
      end
      default: state_nxt = ACCEPT;
    endcase
  end

  // NOTE: all sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ACCEPT;
      wr_spec        <= '0;
      wr_commit      <= '0;
      drop_frame_cnt <= '0;
    end else begin
      state     <= state_nxt;
      wr_spec   <= wr_spec_nxt;
      wr_commit <= wr_commit_nxt;
      if (drop_inc) drop_frame_cnt <= drop_frame_cnt + 32'd1;
    end
  end

  // NOTE: the storage array is deliberately left unreset; pointers alone define
  // which entries are valid, and a resettable array would cost a flop per bit.
  always_ff @(posedge clk) begin
    if (mem_we) mem[wr_spec[AW-1:0]] <= wr_entry;
  end

  assign rd_entry = mem[rd[AW-1:0]];
  assign avail    = rd != wr_commit;
  assign load     = (!tvalid || tready) && avail;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd           <= '0;
      tvalid       <= 1'b0;
      tdata        <= '0;
      tkeep        <= '0;
      tlast        <= 1'b0;
      tx_frame_cnt <= '0;
    end else begin
      if (load) begin
        rd     <= rd + PW'(1);
        tvalid <= 1'b1;
        tdata  <= rd_entry.data;
        tkeep  <= rd_entry.keep;
        tlast  <= rd_entry.last;
      end else if (tready) begin
        tvalid <= 1'b0;
      end
      if (tvalid && tready && tlast) tx_frame_cnt <= tx_frame_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_axi_tx.sv
// Scoreboard bench for axi_tx: expected beats are queued as frames are driven
// and compared against every TX handshake.
module tb_axi_tx;

  localparam int DW    = 64;
  localparam int KW    = DW / 8;
  localparam int DEPTH = 16;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic          last;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          data_valid_in;
  logic [DW-1:0] tdata_in;
  logic [2:0]    idx_in;
  logic          last_flag_in;
  logic          drop_in;
  logic          in_ready;
  logic          tvalid;
  logic [DW-1:0] tdata;
  logic [KW-1:0] tkeep;
  logic          tlast;
  logic          tready;
  logic [31:0]   tx_frame_cnt;
  logic [31:0]   drop_frame_cnt;

  axi_tx #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .data_valid_in  (data_valid_in),
    .tdata_in       (tdata_in),
    .idx_in         (idx_in),
    .last_flag_in   (last_flag_in),
    .drop_in        (drop_in),
    .in_ready       (in_ready),
    .tvalid         (tvalid),
    .tdata          (tdata),
    .tkeep          (tkeep),
    .tlast          (tlast),
    .tready         (tready),
    .tx_frame_cnt   (tx_frame_cnt),
    .drop_frame_cnt (drop_frame_cnt)
  );

  always #5 clk = ~clk;

  int    n_checks = 0;
  int    n_errors = 0;
  beat_t sb_q[$];
  int    exp_tx   = 0;
  int    exp_drop = 0;
  bit    saw_full;
  bit    measure  = 1'b0;
  int    streak;
  int    max_streak;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Compare every accepted beat against the head of the scoreboard.
  always @(negedge clk) begin
    if (!in_ready) saw_full = 1'b1;
    if (rst_n && tvalid && tready) begin
      if (sb_q.size() == 0) begin
        check("unexpected_beat", 64'd1, 64'd0);
      end else begin
        beat_t e;
        e = sb_q.pop_front();
        check("beat_data", tdata, e.data);
        check("beat_keep", 64'(tkeep), 64'(e.keep));
        check("beat_last", 64'(tlast), 64'(e.last));
      end
    end
  end

  always @(negedge clk) begin
    if (!measure) begin
      streak     = 0;
      max_streak = 0;
    end else if (tvalid && tready) begin
      streak++;
      if (streak > max_streak) max_streak = streak;
    end else begin
      streak = 0;
    end
  end

  // Drive one frame; returns 1 time unit after the edge that samples the last word.
  task automatic send_frame(input int n, input int idx, input bit drop, input bit expect_tx);
    for (int i = 0; i < n; i++) begin
      beat_t b;
      b.data = {$urandom, $urandom};
      b.last = (i == n - 1);
      b.keep = b.last ? KW'((16'd1 << (idx + 1)) - 16'd1) : '1;
      data_valid_in = 1'b1;
      tdata_in      = b.data;
      idx_in        = b.last ? 3'(idx) : 3'($urandom_range(0, 7));
      last_flag_in  = b.last;
      drop_in       = b.last ? drop : 1'($urandom_range(0, 1));
      if (expect_tx) sb_q.push_back(b);
      @(posedge clk);
      #1;
    end
    data_valid_in = 1'b0;
    last_flag_in  = 1'b0;
    drop_in       = 1'b0;
    if (expect_tx) exp_tx++;
    else           exp_drop++;
  endtask

  task automatic wait_drain(input string tag);
    bit done = 1'b0;
    for (int c = 0; c < 300 && !done; c++) begin
      @(posedge clk);
      #1;
      if (sb_q.size() == 0 && !tvalid) done = 1'b1;
    end
    if (!done) check({tag, "_drain_timeout"}, 64'(sb_q.size()), 64'd0);
  endtask

  task automatic check_counters(input string tag);
    check({tag, "_tx_cnt"}, 64'(tx_frame_cnt), 64'(exp_tx));
    check({tag, "_drop_cnt"}, 64'(drop_frame_cnt), 64'(exp_drop));
  endtask

  initial begin
    logic [DW-1:0] held_data;
    logic [KW-1:0] held_keep;

    rst_n         = 1'b0;
    data_valid_in = 1'b0;
    tdata_in      = '0;
    idx_in        = '0;
    last_flag_in  = 1'b0;
    drop_in       = 1'b0;
    tready        = 1'b0;
    #12;
    check("rst_tvalid", 64'(tvalid), 64'd0);
    check("rst_tdata", tdata, 64'd0);
    check("rst_tkeep", 64'(tkeep), 64'd0);
    check("rst_tlast", 64'(tlast), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check_counters("rst");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single 3-word frame, tready high: tvalid two cycles after the last word.
    tready = 1'b1;
    send_frame(3, 5, 1'b0, 1'b1);
    check("lat_k", 64'(tvalid), 64'd0);
    @(posedge clk);
    #1;
    check("lat_k1", 64'(tvalid), 64'd1);
    wait_drain("t1");
    check_counters("t1");

    // Backpressure: first beat must hold still while tready is low.
    tready = 1'b0;
    send_frame(3, 2, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    check("bp_tvalid", 64'(tvalid), 64'd1);
    held_data = tdata;
    held_keep = tkeep;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      check("bp_hold_valid", 64'(tvalid), 64'd1);
      check("bp_hold_data", tdata, held_data);
      check("bp_hold_keep", 64'(tkeep), 64'(held_keep));
    end
    tready = 1'b1;
    wait_drain("t2");
    check_counters("t2");

    // Oversized frame is dropped whole; an exactly-DEPTH frame fits.
    tready   = 1'b0;
    saw_full = 1'b0;
    send_frame(DEPTH + 1, 7, 1'b0, 1'b0);
    check("ovf_saw_full", 64'(saw_full), 64'd1);
    check("ovf_in_ready", 64'(in_ready), 64'd1);
    check("ovf_tvalid", 64'(tvalid), 64'd0);
    check_counters("ovf");
    send_frame(DEPTH, 4, 1'b0, 1'b1);
    check("exact_full", 64'(in_ready), 64'd0);
    tready = 1'b1;
    wait_drain("exact");
    send_frame(2, 1, 1'b0, 1'b1);
    wait_drain("t3");
    check_counters("t3");

    // Action-stage drop, then the same frame shape committed; then a 1-word frame.
    send_frame(4, 3, 1'b1, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("drop_tvalid", 64'(tvalid), 64'd0);
    check("drop_in_ready", 64'(in_ready), 64'd1);
    check_counters("drop");
    send_frame(4, 3, 1'b0, 1'b1);
    wait_drain("t4");
    send_frame(1, 0, 1'b0, 1'b1);
    wait_drain("single");
    check_counters("t4");

    // Back-to-back frames while draining: eight beats without a gap.
    measure = 1'b1;
    send_frame(4, 6, 1'b0, 1'b1);
    send_frame(4, 7, 1'b0, 1'b1);
    wait_drain("t5");
    check("b2b_streak", 64'(max_streak), 64'd8);
    measure = 1'b0;
    check_counters("t5");

    // Reset while a frame is on the wire and another is half written.
    send_frame(4, 2, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      data_valid_in = 1'b1;
      tdata_in      = {$urandom, $urandom};
      last_flag_in  = 1'b0;
      @(posedge clk);
      #1;
    end
    #2;
    rst_n         = 1'b0;
    data_valid_in = 1'b0;
    sb_q.delete();
    exp_tx   = 0;
    exp_drop = 0;
    #1;
    check("mid_rst_tvalid", 64'(tvalid), 64'd0);
    check("mid_rst_tdata", tdata, 64'd0);
    check("mid_rst_tkeep", 64'(tkeep), 64'd0);
    check("mid_rst_tlast", 64'(tlast), 64'd0);
    check("mid_rst_in_ready", 64'(in_ready), 64'd1);
    check_counters("mid_rst");
    #10;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send_frame(2, 5, 1'b0, 1'b1);
    wait_drain("t6");
    check_counters("t6");
    check("sb_empty", 64'(sb_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
